crc32_stream_engine: RTL and testbench

CRC32_STREAM_ENGINE -- requirements
Module: crc32_stream_engine

---
 rtl/rx_tx_pkg.sv | 27 ++
 rtl/crc32_byte_lane.sv | 13 +
 rtl/crc32_stream_engine.sv | 173 +++++++++++++++++
 tb/tb_crc32_stream_engine.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_tx_pkg.sv
// Shared CRC-32 (Ethernet, reflected) constants, the engine state type and the
// single-byte update step used by every lane of the stream engine.
package rx_tx_pkg;

    localparam logic [31:0] CRC32_POLY_REFLECTED    = 32'hEDB88320;
    localparam logic [31:0] CRC32_RESIDUE_REFLECTED = 32'hDEBB20E3;
    localparam logic [31:0] CRC32_INIT              = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_FINAL_XOR         = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_HOLD  = 2'd2
    } crc_state_e;

    // Byte enters at the register LSB, so bit 0 of the byte is processed first.
    function automatic logic [31:0] crc32_byte_step(input logic [31:0] crc,
                                                    input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFLECTED) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_byte_lane.sv
// One combinational CRC-32 byte step; a disabled lane passes the register through.
module crc32_byte_lane
    import rx_tx_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    input  logic        en_i,
    output logic [31:0] crc_o
);

    assign crc_o = en_i ? crc32_byte_step(crc_i, data_i) : crc_i;

endmodule

// File: rtl/crc32_stream_engine.sv
// Streaming Ethernet CRC-32 generator/checker: folds DATA_BYTES bytes per beat and
// presents one result per frame (or per aborted frame) on a valid/ready port.
module crc32_stream_engine
    import rx_tx_pkg::*;
#(
    parameter int          DATA_BYTES = 1,
    parameter logic [31:0] INIT_VALUE = CRC32_INIT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*DATA_BYTES-1:0] s_data,
    input  logic [DATA_BYTES-1:0]   s_keep,
    input  logic                    s_sof,
    input  logic                    s_eof,
    input  logic                    s_check,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [31:0]             r_crc,
    output logic                    r_ok,
    output logic                    r_abort,
    output logic                    err_orphan,
    output logic [1:0]              dbg_state
);

    // Handshakes: a beat moves when s_valid & s_ready, a result when r_valid & r_ready,
    // both on the rising clk edge; producers hold their fields stable until accepted.

    crc_state_e  state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] r_crc_q, r_crc_d;
    logic        r_ok_q, r_ok_d;
    logic        r_abort_q, r_abort_d;
    logic        err_orphan_q, err_orphan_d;
    logic        check_q, check_d;
    logic        resume_q, resume_d;
    logic        pend_q, pend_d;

    logic [31:0]           chain [DATA_BYTES+1];
    logic [DATA_BYTES-1:0] lane_en;
    logic [31:0]           fold_out;

    function automatic logic [31:0] result_crc(input logic [31:0] crc, input logic chk);
        return chk ? crc : (crc ^ CRC32_FINAL_XOR);
    endfunction

    function automatic logic result_ok(input logic [31:0] crc, input logic chk);
        return chk ? (crc == CRC32_RESIDUE_REFLECTED) : 1'b1;
    endfunction

    // A new sof always restarts from INIT_VALUE, even when it truncates a frame.
    assign chain[0] = (s_sof || state_q == ST_IDLE) ? INIT_VALUE : crc_q;

    genvar g;
    generate
        for (g = 0; g < DATA_BYTES; g++) begin : g_lane
            // Only the contiguous keep run starting at byte 0 counts, and only on eof.
            assign lane_en[g] = ~s_eof | (&s_keep[g:0]);
            crc32_byte_lane u_lane (
                .crc_i  (chain[g]),
                .data_i (s_data[8*g +: 8]),
                .en_i   (lane_en[g]),
                .crc_o  (chain[g+1])
            );
        end
    endgenerate

    assign fold_out = chain[DATA_BYTES];

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        r_crc_d      = r_crc_q;
        r_ok_d       = r_ok_q;
        r_abort_d    = r_abort_q;
        err_orphan_d = 1'b0;
        check_d      = check_q;
        resume_d     = resume_q;
        pend_d       = pend_q;
        s_ready      = (state_q != ST_HOLD);
        r_valid      = (state_q == ST_HOLD);

        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    if (s_sof) begin
                        crc_d   = fold_out;
                        check_d = s_check;
                        if (s_eof) begin
                            r_crc_d   = result_crc(fold_out, s_check);
                            r_ok_d    = result_ok(fold_out, s_check);
                            r_abort_d = 1'b0;
                            state_d   = ST_HOLD;
                        end else begin
                            state_d = ST_FRAME;
                        end
                    end else begin
                        err_orphan_d = 1'b1;
                    end
                end
            end
            ST_FRAME: begin
                if (s_valid) begin
                    crc_d = fold_out;
                    if (s_sof) begin
                        // Report the truncated frame; the new frame's first beat is
                        // already folded and continues once the result is taken.
                        r_crc_d   = result_crc(crc_q, check_q);
                        r_ok_d    = 1'b0;
                        r_abort_d = 1'b1;
                        check_d   = s_check;
                        pend_d    = s_eof;
                        resume_d  = ~s_eof;
                        state_d   = ST_HOLD;
                    end else if (s_eof) begin
                        r_crc_d   = result_crc(fold_out, check_q);
                        r_ok_d    = result_ok(fold_out, check_q);
                        r_abort_d = 1'b0;
                        state_d   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (r_ready) begin
                    if (pend_q) begin
                        r_crc_d   = result_crc(crc_q, check_q);
                        r_ok_d    = result_ok(crc_q, check_q);
                        r_abort_d = 1'b0;
                        pend_d    = 1'b0;
                    end else if (resume_q) begin
                        resume_d = 1'b0;
                        state_d  = ST_FRAME;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            crc_q        <= INIT_VALUE;
            r_crc_q      <= 32'h0;
            r_ok_q       <= 1'b0;
            r_abort_q    <= 1'b0;
            err_orphan_q <= 1'b0;
            check_q      <= 1'b0;
            resume_q     <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            r_crc_q      <= r_crc_d;
            r_ok_q       <= r_ok_d;
            r_abort_q    <= r_abort_d;
            err_orphan_q <= err_orphan_d;
            check_q      <= check_d;
            resume_q     <= resume_d;
            pend_q       <= pend_d;
        end
    end

    assign r_crc      = r_crc_q;
    assign r_ok       = r_ok_q;
    assign r_abort    = r_abort_q;
    assign err_orphan = err_orphan_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_crc32_stream_engine.sv
// Bench for crc32_stream_engine with four bytes per beat: directed frames, aborts,
// resets and random frames checked against a bit-serial CRC-32 model.
module tb_crc32_stream_engine;

    localparam int DB = 4;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [8*DB-1:0] s_data;
    logic [DB-1:0] s_keep;
    logic          s_sof;
    logic          s_eof;
    logic          s_check;
    logic          r_valid;
    logic          r_ready;
    logic [31:0]   r_crc;
    logic          r_ok;
    logic          r_abort;
    logic          err_orphan;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];   // {abort, ok, crc}
    logic [7:0]  frm[$];

    crc32_stream_engine #(.DATA_BYTES(DB), .INIT_VALUE(32'hFFFFFFFF)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep),
        .s_sof(s_sof), .s_eof(s_eof), .s_check(s_check),
        .r_valid(r_valid), .r_ready(r_ready), .r_crc(r_crc), .r_ok(r_ok),
        .r_abort(r_abort), .err_orphan(err_orphan), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference: each bit LSB-first, reflected polynomial, INIT all-ones.
    function automatic logic [31:0] ref_raw();
        logic [31:0] crc;
        logic        fb;
        crc = 32'hFFFFFFFF;
        foreach (frm[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb  = crc[0] ^ frm[i][k];
                crc = crc >> 1;
                if (fb) crc = crc ^ 32'hEDB88320;
            end
        end
        return crc;
    endfunction

    task automatic push_result(input bit abort, input bit chk);
        logic [31:0] raw;
        logic        ok;
        raw = ref_raw();
        ok  = abort ? 1'b0 : (chk ? (raw == 32'hDEBB20E3) : 1'b1);
        exp_q.push_back({abort, ok, chk ? raw : ~raw});
    endtask

    task automatic fill(input int n);
        frm.delete();
        repeat (n) frm.push_back(8'($urandom));
    endtask

    task automatic send_beat(input logic [31:0] data, input logic [3:0] keep,
                             input bit sof, input bit eof, input bit chk);
        int n;
        @(negedge clk);
        s_valid = 1'b1; s_data = data; s_keep = keep;
        s_sof = sof; s_eof = eof; s_check = chk;
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("s_ready_wait", s_ready, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
        s_data = $urandom; s_check = $urandom_range(0, 1);
    endtask

    task automatic send_bytes(input int from, input int to, input bit sof, input bit eof,
                              input bit chk);
        int i;
        int n;
        bit first;
        logic [31:0] data;
        logic [3:0]  keep;
        i = from;
        first = 1'b1;
        while (i < to) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            n = (to - i > 4) ? 4 : to - i;
            data = $urandom;
            for (int b = 0; b < n; b++) data[8*b +: 8] = frm[i+b];
            if (i + n == to && eof)
                keep = (n == 4) ? 4'hF
                     : (4'((1 << n) - 1) | (4'($urandom) & ~4'((2 << n) - 1)));
            else
                keep = 4'($urandom);
            send_beat(data, keep, sof && first, eof && (i + n == to), chk);
            first = 1'b0;
            i += n;
        end
    endtask

    task automatic expect_result(input string tag, input int stall);
        int n;
        logic [33:0] e;
        n = 0;
        @(negedge clk);
        while (!r_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 0);
        e = exp_q.pop_front();
        check({tag, "_crc"}, r_crc, e[31:0]);
        check({tag, "_ok"}, r_ok, e[32]);
        check({tag, "_abort"}, r_abort, e[33]);
        for (int k = 0; k < stall; k++) begin
            r_ready = 1'b0;
            check({tag, "_stall_s_ready"}, s_ready, 0);
            check({tag, "_stall_r_valid"}, r_valid, 1);
            check({tag, "_stall_fields"}, {r_abort, r_ok, r_crc}, e);
            @(negedge clk);
        end
        r_ready = 1'b1;
        @(posedge clk);
        #1;
        r_ready = 1'b0;
    endtask

    initial begin
        bit chk_a;
        bit chk_b;
        int len;
        logic [31:0] fcs;

        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_keep = '0;
        s_sof = 1'b0; s_eof = 1'b0; s_check = 1'b0; r_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_s_ready", s_ready, 1);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_crc", r_crc, 0);
        check("rst_r_ok", r_ok, 0);
        check("rst_r_abort", r_abort, 0);
        check("rst_err_orphan", err_orphan, 0);

        // "123456789" generate mode: well-known check value.
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        exp_q.push_back({1'b0, 1'b1, 32'hCBF43926});
        send_bytes(0, 9, 1, 1, 0);
        expect_result("gen9", 0);
        @(negedge clk);
        check("idle_after_gen9", r_valid, 0);

        // Same data with its FCS in check mode, result held for 5 cycles.
        frm.push_back(8'h26); frm.push_back(8'h39); frm.push_back(8'hF4); frm.push_back(8'hCB);
        exp_q.push_back({1'b0, 1'b1, 32'hDEBB20E3});
        send_bytes(0, 13, 1, 1, 1);
        expect_result("chk13", 5);

        frm[3] = frm[3] ^ 8'h04;
        push_result(0, 1);
        send_bytes(0, 13, 1, 1, 1);
        expect_result("chk13_flip", 0);

        send_beat($urandom, 4'hF, 0, 0, 0);
        @(negedge clk);
        check("orphan_pulse", err_orphan, 1);
        @(negedge clk);
        check("orphan_clear", err_orphan, 0);
        check("orphan_no_result", r_valid, 0);

        // Eof beat with an empty keep run folds nothing.
        fill(8);
        push_result(0, 0);
        send_bytes(0, 8, 1, 0, 0);
        send_beat($urandom, 4'($urandom) & 4'b1110, 0, 1, 0);
        expect_result("keep0", 0);

        // Sof in the middle of a frame, new frame continues after the aborted result.
        chk_a = $urandom_range(0, 1);
        fill(8);
        push_result(1, chk_a);
        send_bytes(0, 8, 1, 0, chk_a);
        chk_b = $urandom_range(0, 1);
        fill(7);
        send_bytes(0, 4, 1, 0, chk_b);
        expect_result("abort", 0);
        send_bytes(4, 7, 0, 1, chk_b);
        push_result(0, chk_b);
        expect_result("after_abort", 2);

        // Aborting beat that is itself a complete frame yields two results.
        chk_a = $urandom_range(0, 1);
        fill(4);
        push_result(1, chk_a);
        send_bytes(0, 4, 1, 0, chk_a);
        fill(3);
        push_result(0, 0);
        send_bytes(0, 3, 1, 1, 0);
        expect_result("abort2", 0);
        expect_result("abort2_next", 1);

        fill(4);
        send_bytes(0, 4, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rst_mid_r_valid", r_valid, 0);
            check("rst_mid_s_ready", s_ready, 1);
            @(negedge clk);
        end
        fill(5);
        push_result(0, 0);
        send_bytes(0, 5, 1, 1, 0);
        expect_result("post_rst", 0);

        fill(6);
        send_bytes(0, 6, 1, 1, 0);
        @(negedge clk);
        check("hold_before_rst", r_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_hold_r_valid", r_valid, 0);
        check("rst_hold_r_crc", r_crc, 0);
        check("rst_hold_s_ready", s_ready, 1);

        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(1, 24);
            chk_a = $urandom_range(0, 1);
            fill(len);
            if (chk_a) begin
                fcs = ~ref_raw();
                for (int b = 0; b < 4; b++) frm.push_back(fcs[8*b +: 8]);
                if ($urandom_range(0, 3) == 0)
                    frm[$urandom_range(0, frm.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
            end
            push_result(0, chk_a);
            send_bytes(0, frm.size(), 1, 1, chk_a);
            expect_result("rand", $urandom_range(0, 3));
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
